// File: rtl/instr_fetch.sv
// Instruction fetch/dispatch stage: PC, instruction register, field decode
// and start/waiting handshake with the downstream controller.
module instr_fetch #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            mem_rd,
    output logic [PC_W-1:0] mem_addr,
    input  logic [15:0]     mem_rdata,
    input  logic            waiting,
    output logic            start,
    output logic [2:0]      opcode,
    output logic [1:0]      ALU_op,
    output logic [2:0]      rn,
    output logic [2:0]      rd,
    output logic [1:0]      shift_op,
    output logic [2:0]      rm,
    output logic [15:0]     sximm5,
    output logic [15:0]     sximm8,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DISPATCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_HALT
    } state_t;

    state_t          r_state;
    logic [15:0]     r_ir;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_retired;
    logic            r_start;
    logic            r_mem_rd;
    logic            r_halted;
    logic            w_is_halt;

    assign w_is_halt = (mem_rdata[15:13] == 3'b111);

    // Strobes are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_pc      <= '0;
            r_retired <= '0;
            r_start   <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state  <= S_FETCH;
                        r_mem_rd <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_state  <= S_LOAD;
                    r_mem_rd <= 1'b0;
                end
                S_LOAD: begin
                    r_ir <= mem_rdata;
                    if (w_is_halt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= S_DISPATCH;
                        r_start <= 1'b1;
                    end
                end
                S_DISPATCH: begin
                    if (waiting) begin
                        r_start <= 1'b0;
                        r_state <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!waiting) r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (waiting) begin
                        r_retired <= r_retired + 16'd1;
                        if (run) begin
                            r_state  <= S_FETCH;
                            r_mem_rd <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_start  <= 1'b0;
                    r_mem_rd <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_pc;
    assign start    = r_start;
    assign pc       = r_pc;
    assign halted   = r_halted;
    assign retired  = r_retired;

    assign opcode   = r_ir[15:13];
    assign ALU_op   = r_ir[12:11];
    assign rn       = r_ir[10:8];
    assign rd       = r_ir[7:5];
    assign shift_op = r_ir[4:3];
    assign rm       = r_ir[2:0];
    assign sximm5   = {{11{r_ir[4]}}, r_ir[4:0]};
    assign sximm8   = {{8{r_ir[7]}}, r_ir[7:0]};

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory model plus a hand-driven
// controller handshake on the waiting input.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        waiting = 1'b1;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        start;
    logic [2:0]  opcode;
    logic [1:0]  ALU_op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  shift_op;
    logic [2:0]  rm;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] retired;

    logic [15:0] mem [256];

    typedef struct {
        logic [15:0] ir;
        logic [7:0]  pc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_pass = 0;
    int   n_total = 0;

    instr_fetch #(.PC_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .waiting  (waiting),
        .start    (start),
        .opcode   (opcode),
        .ALU_op   (ALU_op),
        .rn       (rn),
        .rd       (rd),
        .shift_op (shift_op),
        .rm       (rm),
        .sximm5   (sximm5),
        .sximm8   (sximm8),
        .pc       (pc),
        .halted   (halted),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        waiting = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_memrd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called one negedge after start was seen (DUT in WAIT_BUSY).
    task automatic finish_instr(input int busy);
        waiting = 1'b0;
        repeat (busy) @(negedge clk);
        waiting = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({start, mem_rd, halted} !== 3'b000)
            $display("FAIL reset_strobes: got %b want 000",
                     {start, mem_rd, halted});
        else n_pass++;
        n_total++;
        if ({pc, mem_addr} !== 16'h0000)
            $display("FAIL reset_pc: got %h want 0000", {pc, mem_addr});
        else n_pass++;
        n_total++;
        if (retired !== 16'd0)
            $display("FAIL reset_retired: got %0d want 0", retired);
        else n_pass++;
        n_total++;
        if ({opcode, ALU_op, rn, rd, shift_op, rm, sximm5, sximm8} !== 48'd0)
            $display("FAIL reset_decode: got %h want 0",
                     {opcode, ALU_op, rn, rd, shift_op, rm, sximm5, sximm8});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_instr();
        bit ok;
        run = 1'b1;
        wait_memrd(ok);
        n_total++;
        if (!ok || mem_addr !== 8'd0)
            $display("FAIL fetch_addr0: got ok=%0d addr=%0d want 1/0",
                     ok, mem_addr);
        else n_pass++;
        sb.push_back('{ir: 16'hD105, pc: 8'd1});
        wait_start(ok);
        e = sb.pop_front();
        n_total++;
        if (!ok)
            $display("FAIL start_timeout1: got none want start");
        else n_pass++;
        n_total++;
        if ({opcode, ALU_op, rn} !== {3'b110, 2'b10, 3'd1})
            $display("FAIL mov_fields: got %b want 11010001",
                     {opcode, ALU_op, rn});
        else n_pass++;
        n_total++;
        if (sximm8 !== 16'h0005)
            $display("FAIL mov_sximm8: got %h want 0005", sximm8);
        else n_pass++;
        n_total++;
        if (pc !== e.pc)
            $display("FAIL mov_pc: got %0d want %0d", pc, e.pc);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (start !== 1'b0)
            $display("FAIL start_one_cycle: got %b want 0", start);
        else n_pass++;
        finish_instr(2);
        n_total++;
        if (retired !== 16'd1)
            $display("FAIL retired1: got %0d want 1", retired);
        else n_pass++;
    endtask

    task automatic test_fields();
        bit ok;
        sb.push_back('{ir: 16'hA3FE, pc: 8'd2});
        wait_start(ok);
        e = sb.pop_front();
        n_total++;
        if (!ok)
            $display("FAIL start_timeout2: got none want start");
        else n_pass++;
        n_total++;
        if ({opcode, rn, rd, shift_op, rm} !== {3'b101, 3'd3, 3'd7, 2'b11, 3'd6})
            $display("FAIL cmp_fields: got %b want 10101111111110",
                     {opcode, rn, rd, shift_op, rm});
        else n_pass++;
        n_total++;
        if (sximm5 !== 16'hFFFE || sximm8 !== 16'hFFFE)
            $display("FAIL cmp_sximm: got %h/%h want FFFE/FFFE",
                     sximm5, sximm8);
        else n_pass++;
        n_total++;
        if (pc !== e.pc)
            $display("FAIL cmp_pc: got %0d want %0d", pc, e.pc);
        else n_pass++;
        @(negedge clk);
        finish_instr(3);
        n_total++;
        if (retired !== 16'd2)
            $display("FAIL retired2: got %0d want 2", retired);
        else n_pass++;
    endtask

    task automatic test_halt();
        bit ok;
        bit saw;
        wait_memrd(ok);
        n_total++;
        if (!ok || mem_addr !== 8'd2)
            $display("FAIL halt_fetch: got ok=%0d addr=%0d want 1/2",
                     ok, mem_addr);
        else n_pass++;
        run = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 10 && halted !== 1'b1; i++) begin
            @(negedge clk);
            if (start === 1'b1) saw = 1'b1;
        end
        n_total++;
        if (halted !== 1'b1)
            $display("FAIL halted: got %b want 1", halted);
        else n_pass++;
        n_total++;
        if (pc !== 8'd2 || saw)
            $display("FAIL halt_pc_start: got pc=%0d start=%0d want 2/0",
                     pc, saw);
        else n_pass++;
        run = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_rd !== 1'b0 || start !== 1'b0 || halted !== 1'b1)
                saw = 1'b1;
        end
        n_total++;
        if (saw)
            $display("FAIL halt_absorb: got activity=1 want 0");
        else n_pass++;
    endtask

    task automatic test_hold_dispatch();
        bit ok;
        int highs;
        do_reset();
        mem[0] = 16'h1234;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        waiting = 1'b0;
        run = 1'b1;
        sb.push_back('{ir: 16'h1234, pc: 8'd1});
        wait_start(ok);
        e = sb.pop_front();
        n_total++;
        if ({opcode, ALU_op, rn, rd, shift_op, rm} !== e.ir)
            $display("FAIL hold_ir: got %h want %h",
                     {opcode, ALU_op, rn, rd, shift_op, rm}, e.ir);
        else n_pass++;
        highs = ok ? 1 : 0;
        repeat (2) begin
            @(negedge clk);
            if (start === 1'b1) highs++;
        end
        n_total++;
        if (highs != 3)
            $display("FAIL hold_start: got %0d high cycles want 3", highs);
        else n_pass++;
        waiting = 1'b1;
        @(negedge clk);
        n_total++;
        if (start !== 1'b0)
            $display("FAIL hold_release: got %b want 0", start);
        else n_pass++;
        finish_instr(2);
        n_total++;
        if (retired !== 16'd1)
            $display("FAIL hold_retired: got %0d want 1", retired);
        else n_pass++;
    endtask

    task automatic test_run_drop();
        bit ok;
        bit saw;
        sb.push_back('{ir: 16'h2222, pc: 8'd2});
        wait_start(ok);
        e = sb.pop_front();
        n_total++;
        if (!ok || {opcode, ALU_op, rn, rd, shift_op, rm} !== e.ir)
            $display("FAIL drop_ir: got %h want %h",
                     {opcode, ALU_op, rn, rd, shift_op, rm}, e.ir);
        else n_pass++;
        @(negedge clk);
        waiting = 1'b0;
        @(negedge clk);
        run = 1'b0;
        waiting = 1'b1;
        @(negedge clk);
        n_total++;
        if (retired !== 16'd2)
            $display("FAIL drop_retired: got %0d want 2", retired);
        else n_pass++;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_rd !== 1'b0 || start !== 1'b0) saw = 1'b1;
        end
        n_total++;
        if (saw || pc !== 8'd2)
            $display("FAIL drop_idle: got act=%0d pc=%0d want 0/2", saw, pc);
        else n_pass++;
        run = 1'b1;
        wait_memrd(ok);
        n_total++;
        if (!ok || mem_addr !== 8'd2)
            $display("FAIL resume_addr: got ok=%0d addr=%0d want 1/2",
                     ok, mem_addr);
        else n_pass++;
        sb.push_back('{ir: 16'h3333, pc: 8'd3});
        wait_start(ok);
        e = sb.pop_front();
        n_total++;
        if (!ok || {opcode, ALU_op, rn, rd, shift_op, rm} !== e.ir || pc !== e.pc)
            $display("FAIL resume_ir: got %h pc=%0d want %h pc=%0d",
                     {opcode, ALU_op, rn, rd, shift_op, rm}, pc, e.ir, e.pc);
        else n_pass++;
        @(negedge clk);
        finish_instr(1);
        n_total++;
        if (retired !== 16'd3)
            $display("FAIL resume_retired: got %0d want 3", retired);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        int bad;
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 16'h4000 | 16'(i);
        run = 1'b1;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            sb.push_back('{ir: mem[i], pc: 8'(i + 1)});
            wait_start(ok);
            e = sb.pop_front();
            if (!ok) begin
                bad++;
                break;
            end
            if ({opcode, ALU_op, rn, rd, shift_op, rm} !== e.ir || pc !== e.pc)
                bad++;
            @(negedge clk);
            finish_instr(1);
        end
        n_total++;
        if (bad != 0)
            $display("FAIL wrap_stream: got %0d bad instrs want 0", bad);
        else n_pass++;
        n_total++;
        if (pc !== 8'd0 || retired !== 16'd256)
            $display("FAIL wrap_pc: got pc=%0d ret=%0d want 0/256",
                     pc, retired);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_start(ok);
        @(negedge clk);
        n_total++;
        if (!ok || pc !== 8'd1)
            $display("FAIL busy_pre: got ok=%0d pc=%0d want 1/1", ok, pc);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (pc !== 8'd0 || retired !== 16'd0 || start !== 1'b0)
            $display("FAIL busy_reset: got pc=%0d ret=%0d st=%b want 0/0/0",
                     pc, retired, start);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_start(ok);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (!ok || start !== 1'b0)
            $display("FAIL dispatch_reset: got ok=%0d start=%b want 1/0",
                     ok, start);
        else n_pass++;
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'hD105;
        mem[1] = 16'hA3FE;
        mem[2] = 16'hE000;
        test_reset();
        test_first_instr();
        test_fields();
        test_halt();
        test_hold_dispatch();
        test_run_drop();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
